// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-address sequencer with redirect/hold arbitration and
// saturating jump/stall performance counters.
`default_nettype none

module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      jump_addr_i,
  input  logic             jump_ena_i,
  input  logic             hold_flag_i,
  input  logic             ext_hold_i,
  output logic [31:0]      pc_o,
  output logic             inst_valid_o,
  output logic             flush_o,
  output logic             hold_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] jump_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    REDIR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   jump_cnt_q, jump_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               misalign_q, misalign_d;
  logic               hold_req;
  logic               jump_acc;
  logic               flush;
  logic               hold;
  logic               valid;

  assign hold_req = hold_flag_i | ext_hold_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      jump_cnt_q  <= '0;
      stall_cnt_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      jump_cnt_q  <= jump_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush    = 1'b0;
    hold     = 1'b0;
    valid    = 1'b0;
    jump_acc = 1'b0;
    case (state_q)
      BOOT: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      // STALL arbitrates exactly like RUN; a jump always beats a hold.
      RUN, STALL: begin
        if (jump_ena_i) begin
          jump_acc = 1'b1;
          flush    = 1'b1;
          pc_d     = {jump_addr_i[31:2], 2'b00};
          state_d  = REDIR;
        end else if (hold_req) begin
          hold    = 1'b1;
          state_d = STALL;
        end else begin
          valid   = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
      end
      // Jumps here come from a flushed bubble in ex and are dropped.
      REDIR: begin
        if (hold_req) begin
          hold    = 1'b1;
          state_d = STALL;
        end else begin
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    jump_cnt_d  = jump_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (jump_acc && !(&jump_cnt_q)) begin
      jump_cnt_d = jump_cnt_q + CNT_ONE;
    end
    if ((state_q == STALL) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    misalign_d = jump_acc && (jump_addr_i[1:0] != 2'b00);
  end

  assign pc_o         = pc_q;
  assign flush_o      = flush;
  assign hold_o       = hold;
  assign inst_valid_o = valid & ~flush & ~hold;
  assign misalign_o   = misalign_q;
  assign jump_cnt_o   = jump_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed checks of pc_ctrl sequencing, arbitration, counters
// and reset behaviour, using two instances (default and wrap/saturation).
`default_nettype none

module tb_pc_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_n = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        jump_ena = 1'b0, hold_flag = 1'b0, ext_hold = 1'b0;
  logic [31:0] pc;
  logic        valid, flush, hold, misalign;
  logic [31:0] jcnt, scnt;

  // Instance B: wrap-around reset PC and 2-bit counters
  logic        rst_nb = 1'b0;
  logic [31:0] jump_addr_b = '0;
  logic        jump_ena_b = 1'b0;
  logic [31:0] pc_b;
  logic        valid_b, flush_b, hold_b, misalign_b;
  logic [1:0]  jcnt_b, scnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  pc_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .jump_addr_i(jump_addr), .jump_ena_i(jump_ena),
    .hold_flag_i(hold_flag), .ext_hold_i(ext_hold), .pc_o(pc),
    .inst_valid_o(valid), .flush_o(flush), .hold_o(hold), .misalign_o(misalign),
    .jump_cnt_o(jcnt), .stall_cnt_o(scnt)
  );

  pc_ctrl #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_nb), .jump_addr_i(jump_addr_b), .jump_ena_i(jump_ena_b),
    .hold_flag_i(1'b0), .ext_hold_i(1'b0), .pc_o(pc_b),
    .inst_valid_o(valid_b), .flush_o(flush_b), .hold_o(hold_b), .misalign_o(misalign_b),
    .jump_cnt_o(jcnt_b), .stall_cnt_o(scnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs may then be changed and outputs sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_hold", {31'b0, hold}, 32'd0);
    chk("rst_jcnt", jcnt, 32'd0);
    chk("rst_scnt", scnt, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    #10;
    rst_n = 1'b1;                       // released away from a rising edge
    #1;
    // Boot sequence: pc 0,0,4,8 ; valid 0,1,1,1
    chk("boot_pc0", pc, 32'h0);
    chk("boot_v0", {31'b0, valid}, 32'd0);
    step(); chk("boot_pc1", pc, 32'h0); chk("boot_v1", {31'b0, valid}, 32'd1);
    step(); chk("boot_pc2", pc, 32'h4); chk("boot_v2", {31'b0, valid}, 32'd1);
    step(); chk("boot_pc3", pc, 32'h8); chk("boot_v3", {31'b0, valid}, 32'd1);
    step(); step();
    chk("run_pc10", pc, 32'h10);

    // Redirect from 0x10 to 0x100
    jump_ena = 1'b1; jump_addr = 32'h100; #1;
    chk("j1_flush", {31'b0, flush}, 32'd1);
    chk("j1_valid", {31'b0, valid}, 32'd0);
    step(); jump_ena = 1'b0; #1;
    chk("j1_pc", pc, 32'h100);
    chk("j1_redir_valid", {31'b0, valid}, 32'd0);
    chk("j1_redir_flush", {31'b0, flush}, 32'd0);
    chk("j1_jcnt", jcnt, 32'd1);
    chk("j1_mis", {31'b0, misalign}, 32'd0);
    step();
    chk("j1_pc_next", pc, 32'h104);
    chk("j1_valid_next", {31'b0, valid}, 32'd1);

    // Jump to 0x1C so the following RUN cycle sits at 0x20
    jump_ena = 1'b1; jump_addr = 32'h1C; #1;
    step(); jump_ena = 1'b0; #1;
    chk("j2_pc", pc, 32'h1C);
    step();
    chk("pre_hold_pc", pc, 32'h20);

    // hold_flag high for three cycles at 0x20
    hold_flag = 1'b1; #1;
    chk("h_hold0", {31'b0, hold}, 32'd1);
    chk("h_valid0", {31'b0, valid}, 32'd0);
    step();
    chk("h_pc1", pc, 32'h20); chk("h_hold1", {31'b0, hold}, 32'd1);
    chk("h_valid1", {31'b0, valid}, 32'd0);
    step();
    chk("h_pc2", pc, 32'h20); chk("h_scnt2", scnt, 32'd1);
    step(); hold_flag = 1'b0; #1;
    chk("h_exit_hold", {31'b0, hold}, 32'd0);
    chk("h_exit_pc", pc, 32'h20);
    step();
    chk("h_after_pc", pc, 32'h24);
    chk("h_scnt", scnt, 32'd3);

    // Jump and ext_hold together, misaligned target
    jump_ena = 1'b1; ext_hold = 1'b1; jump_addr = 32'h203; #1;
    chk("jh_hold", {31'b0, hold}, 32'd0);
    chk("jh_flush", {31'b0, flush}, 32'd1);
    step(); ext_hold = 1'b0; jump_addr = 32'h400; #1;   // jump still high in REDIR
    chk("jh_pc", pc, 32'h200);
    chk("jh_mis", {31'b0, misalign}, 32'd1);
    chk("jh_jcnt", jcnt, 32'd3);
    chk("redir_ign_flush", {31'b0, flush}, 32'd0);
    step(); jump_ena = 1'b0; #1;
    chk("redir_ign_pc", pc, 32'h204);
    chk("redir_ign_jcnt", jcnt, 32'd3);
    chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
    step();
    chk("pc_208", pc, 32'h208);

    // Stall, then jump out of STALL, then REDIR into STALL, then reset
    hold_flag = 1'b1; #1;
    step(); step(); step();
    chk("s_scnt5", scnt, 32'd5);
    jump_ena = 1'b1; jump_addr = 32'h300; #1;
    chk("sj_flush", {31'b0, flush}, 32'd1);
    chk("sj_hold", {31'b0, hold}, 32'd0);
    step(); jump_ena = 1'b0; #1;
    chk("sj_pc", pc, 32'h300);
    chk("sj_jcnt", jcnt, 32'd4);
    chk("redir_hold", {31'b0, hold}, 32'd1);
    chk("redir_hold_valid", {31'b0, valid}, 32'd0);
    step();
    chk("redir_stall_pc", pc, 32'h300);
    #2;
    rst_n = 1'b0; #1;
    chk("ar_pc", pc, 32'h0);
    chk("ar_scnt", scnt, 32'd0);
    chk("ar_jcnt", jcnt, 32'd0);
    chk("ar_hold", {31'b0, hold}, 32'd0);
    chk("ar_flush", {31'b0, flush}, 32'd1);
    hold_flag = 1'b0;

    // Instance B: wrap from FFFF_FFF8 and counter saturation
    @(negedge clk);
    rst_nb = 1'b1; #1;
    chk("b_pc0", pc_b, 32'hFFFF_FFF8);
    step(); chk("b_pc1", pc_b, 32'hFFFF_FFF8);
    step(); chk("b_pc2", pc_b, 32'hFFFF_FFFC);
    step(); chk("b_pc3", pc_b, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      jump_ena_b = 1'b1; jump_addr_b = 32'h40; #1;
      step(); jump_ena_b = 1'b0; #1;
      step();
    end
    chk("b_jcnt_sat", {30'b0, jcnt_b}, 32'd3);
    chk("b_pc_after", pc_b, 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
